// File: rtl/recepcion.sv
// Serial receiver for the 3-bit code link: samples each bit twice, MSB first,
// and reports good frames (valid + dataout + okcount) or rejected ones (err).
module recepcion (
    input  logic       clk4,
    input  logic       reset4,
    input  logic       start,
    input  logic       sda,
    output logic [2:0] dataout,
    output logic       valid,
    output logic       err,
    output logic       busy,
    output logic [3:0] okcount
);

    typedef enum logic [2:0] {
        IDLE, S2A, S2B, S1A, S1B, S0A, S0B, WAITLOW
    } state_t;

    state_t     state;
    logic [4:0] samp;       // first five samples, oldest in the MSB
    logic       mismatch;
    logic [2:0] code;

    // The sixth sample is the live sda on the S0B edge
    assign mismatch = (samp[4] != samp[3]) | (samp[2] != samp[1]) | (samp[0] != sda);
    assign code     = {samp[4], samp[2], samp[0]};

    always_ff @(posedge clk4 or posedge reset4) begin
        if (reset4) begin
            state   <= IDLE;
            samp    <= '0;
            dataout <= 3'b000;
            valid   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            okcount <= 4'd0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= S2A;
                        busy  <= 1'b1;
                    end
                end
                S2A: begin
                    samp  <= {samp[3:0], sda};
                    state <= S2B;
                end
                S2B: begin
                    samp  <= {samp[3:0], sda};
                    state <= S1A;
                end
                S1A: begin
                    samp  <= {samp[3:0], sda};
                    state <= S1B;
                end
                S1B: begin
                    samp  <= {samp[3:0], sda};
                    state <= S0A;
                end
                S0A: begin
                    samp  <= {samp[3:0], sda};
                    state <= S0B;
                end
                S0B: begin
                    busy <= 1'b0;
                    if (mismatch || code == 3'b000 || code == 3'b111) begin
                        err <= 1'b1;
                    end else begin
                        dataout <= code;
                        valid   <= 1'b1;
                        okcount <= okcount + 4'd1;
                    end
                    // A strobe still high must be seen low before re-arming
                    state <= start ? WAITLOW : IDLE;
                end
                WAITLOW: begin
                    if (!start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recepcion.sv
// Randomized self-checking bench for recepcion with a frame-level reference model.
module tb_recepcion;

    logic       clk4;
    logic       reset4;
    logic       start;
    logic       sda;
    logic [2:0] dataout;
    logic       valid;
    logic       err;
    logic       busy;
    logic [3:0] okcount;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: what the receiver should be holding
    int exp_count = 0;
    int exp_data  = 0;

    recepcion dut (
        .clk4    (clk4),
        .reset4  (reset4),
        .start   (start),
        .sda     (sda),
        .dataout (dataout),
        .valid   (valid),
        .err     (err),
        .busy    (busy),
        .okcount (okcount)
    );

    initial begin
        clk4 = 1'b0;
        forever #5 clk4 = ~clk4;
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycles with no frame being started; start held at start_val
    task automatic idle(input int n, input bit start_val);
        for (int i = 0; i < n; i++) begin
            start = start_val;
            sda   = 1'($urandom_range(0, 1));
            @(posedge clk4); #1;
            chk("idle_valid", int'(valid), 0);
            chk("idle_err", int'(err), 0);
            chk("idle_busy", int'(busy), 0);
        end
    endtask

    // Send one frame: s holds the six line values in transmit order (s[5] first).
    // Called just after an edge; that following edge is edge k.
    task automatic frame(input logic [5:0] s, input bit drop, input bit hold);
        logic [2:0] c;
        bit         good;
        start = 1'b1;
        @(posedge clk4); #1;
        chk("k_valid_clear", int'(valid), 0);
        chk("k_err_clear", int'(err), 0);
        chk("k_busy", int'(busy), 1);
        for (int j = 0; j < 6; j++) begin
            sda = s[5 - j];
            if (drop && j == 3) start = 1'b0;
            if (j == 5) start = hold;
            @(posedge clk4); #1;
            if (j < 5) begin
                chk("mid_busy", int'(busy), 1);
                chk("mid_valid", int'(valid), 0);
                chk("mid_err", int'(err), 0);
            end
        end
        c    = {s[5], s[3], s[1]};
        good = (s[5] == s[4]) && (s[3] == s[2]) && (s[1] == s[0]) &&
               (c != 3'b000) && (c != 3'b111);
        if (good) begin
            exp_data  = int'(c);
            exp_count = (exp_count + 1) % 16;
        end
        $display("[TB] frame sda=%b drop=%0d hold=%0d -> valid=%0d err=%0d data=%0d cnt=%0d",
                 s, drop, hold, valid, err, dataout, okcount);
        chk("res_valid", int'(valid), good ? 1 : 0);
        chk("res_err", int'(err), good ? 0 : 1);
        chk("res_data", int'(dataout), exp_data);
        chk("res_count", int'(okcount), exp_count);
        chk("res_busy", int'(busy), 0);
    endtask

    function automatic logic [5:0] dbl(input logic [2:0] c);
        return {c[2], c[2], c[1], c[1], c[0], c[0]};
    endfunction

    initial begin
        logic [5:0] s;
        int         gap;
        reset4 = 1'b1;
        start  = 1'b0;
        sda    = 1'b0;
        repeat (3) @(posedge clk4);
        #1;
        chk("rst_data", int'(dataout), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(okcount), 0);
        reset4 = 1'b0;
        idle(2, 1'b0);

        // Directed: good, mismatch, two illegal codes
        frame(6'b110011, 1'b1, 1'b0);
        frame(6'b111000, 1'b0, 1'b0);
        frame(6'b000000, 1'b0, 1'b0);
        frame(6'b111111, 1'b0, 1'b0);

        // Held start: a second frame under a high strobe is not captured
        frame(dbl(3'b010), 1'b0, 1'b1);
        idle(7, 1'b1);
        idle(1, 1'b0);
        frame(dbl(3'b011), 1'b0, 1'b0);

        // Reset in the middle of a frame
        start = 1'b1;
        @(posedge clk4); #1;
        for (int j = 0; j < 3; j++) begin
            sda = 1'b1;
            @(posedge clk4); #1;
        end
        reset4 = 1'b1;
        #1;
        exp_count = 0;
        exp_data  = 0;
        $display("[TB] mid-frame reset -> data=%0d cnt=%0d busy=%0d", dataout, okcount, busy);
        chk("mrst_data", int'(dataout), 0);
        chk("mrst_valid", int'(valid), 0);
        chk("mrst_err", int'(err), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_count", int'(okcount), 0);
        start = 1'b0;
        @(negedge clk4);
        reset4 = 1'b0;
        @(posedge clk4); #1;
        idle(6, 1'b0);

        // Wrap: 16 good frames at minimum spacing
        for (int i = 0; i < 16; i++) begin
            frame(dbl(3'(1 + (i % 6))), 1'b0, 1'b0);
        end
        chk("wrap_count", int'(okcount), 0);

        // Randomized frames
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1)
                s = dbl(3'($urandom_range(1, 6)));
            else
                s = 6'($urandom);
            frame(s, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            if (start) begin
                idle(int'($urandom_range(0, 4)), 1'b1);
                idle(1, 1'b0);
            end
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle(gap, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
